// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Carries NCH payload channels of W bits; in_ready is registered and the skid
// entry absorbs the word that arrives in the cycle in_ready is still high.
module pipe_stage_hs #(
  parameter int unsigned W       = 32,
  parameter int unsigned NCH     = 5,
  parameter int unsigned PC_CH   = 1,
  parameter int unsigned KEEP_PC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH*W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH*W-1:0] out_data,
  input  logic             flush,
  input  logic [W-1:0]     flush_pc,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [NCH*W-1:0]   skid_data;
  logic [NCH*W-1:0]   main_n;
  logic [NCH*W-1:0]   skid_n;
  logic [NCH*W-1:0]   flush_word;
  logic               skid_valid;
  logic               accept;
  logic               pop;

  // Occupancy, out_valid and skid_valid are all decodes of the state register.
  assign out_valid  = (state != S_EMPTY);
  assign skid_valid = (state == S_FULL);
  assign occupancy  = state;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Bubble payload loaded on flush: all zero, optionally keeping the PC.
  always_comb begin
    flush_word = '0;
    if (KEEP_PC != 0) begin
      flush_word[PC_CH*W +: W] = flush_pc;
    end
  end

  // Next-state and next-payload selection; flush overrides accept and pop.
  always_comb begin
    state_n = state;
    main_n  = out_data;
    skid_n  = skid_data;
    unique case (state)
      S_EMPTY: begin
        if (accept) begin
          state_n = S_ONE;
          main_n  = in_data;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          main_n = in_data;
        end else if (accept) begin
          state_n = S_FULL;
          skid_n  = in_data;
        end else if (pop) begin
          state_n = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_n = S_ONE;
          main_n  = skid_data;
        end
      end
      default: begin
        state_n = S_EMPTY;
      end
    endcase
    if (flush) begin
      state_n = S_EMPTY;
      main_n  = flush_word;
    end
  end

  // State and payload registers; in_ready is precomputed from the next state
  // so it is a flop output with no path from out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n != S_FULL);
      out_data  <= main_n;
      skid_data <= skid_n;
    end
  end

  // skid_valid is kept as a named decode for readability of waveforms.
  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: default build (KEEP_PC=1), a KEEP_PC=0
// twin sharing the same stimulus, and a narrow W=16/NCH=3/PC_CH=0 build.
module tb_pipe_stage_hs;

  logic         clk = 1'b0;
  logic         reset;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32-bit/5-channel instances.
  logic         in_valid;
  logic [159:0] in_data;
  logic         out_ready;
  logic         flush;
  logic [31:0]  flush_pc;

  logic         a_in_ready, a_out_valid;
  logic [159:0] a_out_data;
  logic [1:0]   a_occupancy;
  logic         b_in_ready, b_out_valid;
  logic [159:0] b_out_data;
  logic [1:0]   b_occupancy;

  // Narrow instance stimulus/outputs.
  logic         c_in_valid;
  logic [47:0]  c_in_data;
  logic         c_out_ready;
  logic         c_flush;
  logic [15:0]  c_flush_pc;
  logic         c_in_ready, c_out_valid;
  logic [47:0]  c_out_data;
  logic [1:0]   c_occupancy;

  pipe_stage_hs #(.W(32), .NCH(5), .PC_CH(1), .KEEP_PC(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .flush(flush), .flush_pc(flush_pc),
    .occupancy(a_occupancy)
  );

  pipe_stage_hs #(.W(32), .NCH(5), .PC_CH(1), .KEEP_PC(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .flush(flush), .flush_pc(flush_pc),
    .occupancy(b_occupancy)
  );

  pipe_stage_hs #(.W(16), .NCH(3), .PC_CH(0), .KEEP_PC(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .flush(c_flush), .flush_pc(c_flush_pc),
    .occupancy(c_occupancy)
  );

  int checks = 0;
  int errors = 0;
  logic [159:0] qa[$];
  logic [159:0] qb[$];
  logic [47:0]  qc[$];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // 5-channel word: ch0=instr, ch1=pc, ch2=~instr, ch3=instr<<8, ch4=tag|instr.
  function automatic logic [159:0] mk(input logic [31:0] i);
    return {32'hD000_0000 | i, i << 8, ~i, 32'h0000_1000 + (i << 2), i};
  endfunction

  // 3-channel word: ch0=pc, ch1=0x00A0+i, ch2=0xC000|i.
  function automatic logic [47:0] mkc(input logic [15:0] i);
    return {16'hC000 | i, 16'h00A0 + i, 16'h0200 + (i << 2)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ab(input logic [159:0] w);
    qa.push_back(w);
    qb.push_back(w);
  endtask

  // Monitors: every completed output handshake must match the queue head.
  always @(negedge clk) begin
    if (reset && a_out_valid && out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_mon_unexpected: got %h expected none", a_out_data);
      end else chk("a_mon", a_out_data, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset && b_out_valid && out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_mon_unexpected: got %h expected none", b_out_data);
      end else chk("b_mon", b_out_data, qb.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_mon_unexpected: got %h expected none", c_out_data);
      end else chk("c_mon", 160'(c_out_data), 160'(qc.pop_front()));
    end
  end

  logic [159:0] fa;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; flush_pc = '0;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0; c_flush = 1'b0; c_flush_pc = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 160'(a_out_valid), 160'd0);
    chk("rst_occupancy", 160'(a_occupancy), 160'd0);
    chk("rst_in_ready", 160'(a_in_ready), 160'd1);
    chk("rst_out_data", a_out_data, '0);
    chk("rst_c_in_ready", 160'(c_in_ready), 160'd1);
    step(); step();
    reset = 1'b1;

    // Streaming: one word per cycle, one-cycle latency, occupancy stays 1.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = mk(32'(i));
      push_ab(mk(32'(i)));
      step();
      chk("stream_occ", 160'(a_occupancy), 160'd1);
      chk("stream_in_ready", 160'(a_in_ready), 160'd1);
      chk("stream_data", a_out_data, mk(32'(i)));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_occ", 160'(a_occupancy), 160'd0);
    chk("hold_after_pop", a_out_data, mk(32'd8));

    // Skid fill under back-pressure, then drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'hAAAA_0001); push_ab(mk(32'hAAAA_0001));
    step();
    chk("skid_one_in_ready", 160'(a_in_ready), 160'd1);
    in_data = mk(32'hBBBB_0002); push_ab(mk(32'hBBBB_0002));
    step();
    chk("skid_full_occ", 160'(a_occupancy), 160'd2);
    chk("skid_full_in_ready", 160'(a_in_ready), 160'd0);
    chk("skid_full_main", a_out_data, mk(32'hAAAA_0001));
    in_data = mk(32'hCCCC_0003); push_ab(mk(32'hCCCC_0003));
    step();
    chk("skid_c_refused_occ", 160'(a_occupancy), 160'd2);
    chk("skid_c_refused_main", a_out_data, mk(32'hAAAA_0001));
    out_ready = 1'b1;
    step();
    chk("skid_pop1_occ", 160'(a_occupancy), 160'd1);
    chk("skid_pop1_in_ready", 160'(a_in_ready), 160'd1);
    chk("skid_pop1_main", a_out_data, mk(32'hBBBB_0002));
    step();
    chk("accept_pop_occ", 160'(a_occupancy), 160'd1);
    chk("accept_pop_main", a_out_data, mk(32'hCCCC_0003));
    in_valid = 1'b0;
    step();
    chk("skid_drain_occ", 160'(a_occupancy), 160'd0);

    // Flush in FULL with a word offered: bubble keeps PC (A) or zero (B).
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'd30); push_ab(mk(32'd30));
    step();
    in_data = mk(32'd31); push_ab(mk(32'd31));
    step();
    chk("pre_flush_occ", 160'(a_occupancy), 160'd2);
    in_data = mk(32'd32);
    flush = 1'b1; flush_pc = 32'h0000_3008;
    step();
    flush = 1'b0; in_valid = 1'b0;
    qa.delete(); qb.delete();
    fa = '0;
    fa[63:32] = 32'h0000_3008;
    chk("flush_out_valid", 160'(a_out_valid), 160'd0);
    chk("flush_occ", 160'(a_occupancy), 160'd0);
    chk("flush_in_ready", 160'(a_in_ready), 160'd1);
    chk("flush_keep_pc_data", a_out_data, fa);
    chk("flush_nokeep_data", b_out_data, '0);
    chk("flush_nokeep_occ", 160'(b_occupancy), 160'd0);
    out_ready = 1'b1;
    step(); step();
    chk("flush_no_leak", 160'(a_out_valid), 160'd0);

    // Async reset mid-cycle while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'd20); push_ab(mk(32'd20));
    step();
    in_data = mk(32'd21); push_ab(mk(32'd21));
    step();
    in_valid = 1'b0;
    chk("pre_reset_occ", 160'(a_occupancy), 160'd2);
    #2 reset = 1'b0;
    #1;
    qa.delete(); qb.delete();
    chk("areset_out_valid", 160'(a_out_valid), 160'd0);
    chk("areset_occ", 160'(a_occupancy), 160'd0);
    chk("areset_in_ready", 160'(a_in_ready), 160'd1);
    chk("areset_out_data", a_out_data, '0);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step(); step();
    chk("post_reset_no_leak", 160'(a_out_valid), 160'd0);
    in_valid = 1'b1; in_data = mk(32'd9); push_ab(mk(32'd9));
    step();
    in_valid = 1'b0;
    chk("post_reset_word", a_out_data, mk(32'd9));
    step();

    // Narrow build: streaming with channel packing, then flush keeping PC in ch0.
    c_out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      c_in_valid = 1'b1;
      c_in_data  = mkc(16'(i));
      qc.push_back(mkc(16'(i)));
      step();
      chk("c_stream_occ", 160'(c_occupancy), 160'd1);
      chk("c_stream_data", 160'(c_out_data), 160'(mkc(16'(i))));
      if (i == 1) chk("c_packing", 160'(c_out_data), 160'(48'hC001_00A1_0204));
    end
    c_in_valid = 1'b0;
    step();
    c_out_ready = 1'b0;
    c_in_valid = 1'b1; c_in_data = mkc(16'd7); qc.push_back(mkc(16'd7));
    step();
    c_in_data = mkc(16'd8); qc.push_back(mkc(16'd8));
    step();
    chk("c_pre_flush_occ", 160'(c_occupancy), 160'd2);
    c_in_data = mkc(16'd9);
    c_flush = 1'b1; c_flush_pc = 16'h3008;
    step();
    c_flush = 1'b0; c_in_valid = 1'b0;
    qc.delete();
    chk("c_flush_occ", 160'(c_occupancy), 160'd0);
    chk("c_flush_data", 160'(c_out_data), 160'(48'h0000_0000_3008));
    c_out_ready = 1'b1;
    step(); step();
    chk("c_flush_no_leak", 160'(c_out_valid), 160'd0);

    chk("qa_empty", 160'(qa.size()), 160'd0);
    chk("qb_empty", 160'(qb.size()), 160'd0);
    chk("qc_empty", 160'(qc.size()), 160'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
